// File: rtl/dl_spi_master_if.sv
// Command/response and SPI pin bundle for dl_spi_master.
//   cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata                           : completion pulse and read data
//   busy                                          : transaction in progress
//   spi_cs_n/spi_sclk/spi_mosi/spi_miso           : SPI mode 0 pins
// Modport master is the controller side (dl_spi_master), slave is its peer.
interface dl_spi_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
    output cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, spi_miso,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/dl_spi_master.sv
// SPI mode 0 master for the delay-line register interface.
// One 16-bit frame per command: {rw, addr[6:0], wdata[7:0]} MSB first,
// data byte forced to 0 for reads; the last 8 MISO samples form rsp_rdata.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : dl_spi_master_if.master (command, response, SPI pins)
// CLK_DIV (1..255) is the SCLK half-period in clk cycles.
module dl_spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  dl_spi_master_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

  logic        cmd_ready;
  logic        accept;
  logic [15:0] frame;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign frame     = {bus.cmd_rw, bus.cmd_addr, bus.cmd_rw ? 8'h00 : bus.cmd_wdata};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = frame[15];
          // Remaining bits wait at the top; zeros shifted in give mosi=0
          // after the 16th falling edge without a special case.
          tx_d    = {frame[14:0], 1'b0};
          div_d   = DIV_LAST;
        end
      end

      S_SETUP: begin
        if (div_q == '0) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[6:0], bus.spi_miso};
          bit_d   = '0;
          div_d   = DIV_LAST;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - 8'd1;
        end else if (sclk_q) begin
          sclk_d = 1'b0;
          mosi_d = tx_q[15];
          tx_d   = {tx_q[14:0], 1'b0};
          div_d  = DIV_LAST;
        end else if (bit_q == 5'd15) begin
          state_d = S_HOLD;
          div_d   = DIV_LAST;
        end else begin
          bit_d  = bit_q + 5'd1;
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], bus.spi_miso};
          div_d  = DIV_LAST;
        end
      end

      S_HOLD: begin
        if (div_q == '0) begin
          state_d     = S_GAP;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
          div_d       = DIV_LAST;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      S_GAP: begin
        if (div_q == '0) begin
          state_d = S_IDLE;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;

endmodule

// File: tb/tb_dl_spi_master.sv
// Self-checking bench for dl_spi_master: one instance with CLK_DIV=2 and one
// with CLK_DIV=1. A pin-level monitor per instance records each cs_n-low
// frame (MOSI word seen on SCLK rises, bit count, low/high run lengths) and
// plays a MISO word back, changing bits on SCLK falls.
module tb_dl_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v;
  logic [1:0] cv;
  logic [1:0] crw;
  logic [6:0] caddr [2];
  logic [7:0] cwd   [2];
  logic [1:0] miso_v = '0;

  dl_spi_master_if if0 ();
  dl_spi_master_if if1 ();

  assign if0.cmd_valid = cv[0];
  assign if0.cmd_rw    = crw[0];
  assign if0.cmd_addr  = caddr[0];
  assign if0.cmd_wdata = cwd[0];
  assign if0.spi_miso  = miso_v[0];
  assign if1.cmd_valid = cv[1];
  assign if1.cmd_rw    = crw[1];
  assign if1.cmd_addr  = caddr[1];
  assign if1.cmd_wdata = cwd[1];
  assign if1.spi_miso  = miso_v[1];

  dl_spi_master #(.CLK_DIV(2)) u_d2 (.clk(clk), .rst(rst_v[0]), .bus(if0));
  dl_spi_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst(rst_v[1]), .bus(if1));

  logic [1:0] cs_w, sclk_w, mosi_w, ready_w, rv_w, busy_w;
  logic [7:0] rdata_w [2];
  assign cs_w    = {if1.spi_cs_n,  if0.spi_cs_n};
  assign sclk_w  = {if1.spi_sclk,  if0.spi_sclk};
  assign mosi_w  = {if1.spi_mosi,  if0.spi_mosi};
  assign ready_w = {if1.cmd_ready, if0.cmd_ready};
  assign rv_w    = {if1.rsp_valid, if0.rsp_valid};
  assign busy_w  = {if1.busy,      if0.busy};
  assign rdata_w[0] = if0.rsp_rdata;
  assign rdata_w[1] = if1.rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor / MISO model state
  logic [15:0] miso_word [2];
  logic [15:0] mcur      [2];
  int          midx      [2];
  logic [1:0]  prev_cs = '1;
  logic [1:0]  prev_sc = '0;
  logic [15:0] acc       [2];
  int          nb        [2];
  int          lowlen    [2];
  int          highlen   [2];
  int          pulses    [2];
  int          tail_err = 0;
  int          f_n       [2];
  logic [15:0] f_mosi    [2][32];
  int          f_nb      [2][32];
  int          f_low     [2][32];
  int          f_high    [2][32];
  logic [7:0]  f_rd      [2][32];

  initial begin
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; lowlen[k] = 0; highlen[k] = 0; pulses[k] = 0; f_n[k] = 0;
      acc[k] = '0; mcur[k] = '0; midx[k] = 0; miso_word[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rv_w[k]) pulses[k]++;
      if (!cs_w[k]) begin
        if (prev_cs[k]) begin
          if (f_n[k] < 32) f_high[k][f_n[k]] = highlen[k];
          lowlen[k] = 0;
          nb[k]     = 0;
          acc[k]    = '0;
          mcur[k]   = miso_word[k];
          midx[k]   = 15;
          miso_v[k] = mcur[k][15];
        end
        lowlen[k]++;
        if (sclk_w[k] && !prev_sc[k]) begin
          acc[k] = {acc[k][14:0], mosi_w[k]};
          nb[k]++;
        end
        if (!sclk_w[k] && prev_sc[k] && midx[k] > 0) begin
          midx[k]--;
          miso_v[k] = mcur[k][midx[k]];
        end
        if (nb[k] == 16 && !sclk_w[k] && mosi_w[k]) tail_err++;
      end else begin
        if (!prev_cs[k]) begin
          if (f_n[k] < 32) begin
            f_mosi[k][f_n[k]] = acc[k];
            f_nb[k][f_n[k]]   = nb[k];
            f_low[k][f_n[k]]  = lowlen[k];
            f_rd[k][f_n[k]]   = rdata_w[k];
          end
          f_n[k]++;
          highlen[k] = 0;
        end
        highlen[k]++;
      end
      prev_cs[k] = cs_w[k];
      prev_sc[k] = sclk_w[k];
    end
  end

  function automatic int dv(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Frame expected on MOSI from the command fields
  function automatic logic [15:0] exp_frame(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int v;
    v = (int'(rw) << 15) + (int'(a) << 8) + (rw ? 0 : int'(d));
    return 16'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int k);
    int t = 0;
    while (!ready_w[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 32'(ready_w[k]), 32'd1);
  endtask

  task automatic do_txn(input int k, input logic rw, input logic [6:0] a,
                        input logic [7:0] d, input logic [15:0] mw, input bit disturb);
    logic [15:0] f;
    int base, fidx, t;
    f = exp_frame(rw, a, d);
    miso_word[k] = mw;
    @(negedge clk);
    wait_ready(k);
    base = pulses[k];
    fidx = f_n[k];
    cv[k] = 1'b1; crw[k] = rw; caddr[k] = a; cwd[k] = d;
    @(posedge clk);
    #1;
    cv[k] = 1'b0; crw[k] = ~rw; caddr[k] = ~a; cwd[k] = ~d;
    @(negedge clk);
    check("accept_state", {busy_w[k], ready_w[k], cs_w[k], mosi_w[k]},
          {28'd0, 1'b1, 1'b0, 1'b0, f[15]});
    if (disturb) begin
      repeat (20) @(negedge clk);
      cv[k] = 1'b1;
      caddr[k] = a ^ 7'h55;
      @(negedge clk);
      cv[k] = 1'b0;
      caddr[k] = ~caddr[k];
    end
    t = 0;
    while (!rv_w[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rsp_seen", 32'(rv_w[k]), 32'd1);
    check("rdata", 32'(rdata_w[k]), 32'(mw[7:0]));
    @(negedge clk);
    check("rsp_one_cycle", 32'(rv_w[k]), 32'd0);
    check("frame_count", 32'(f_n[k]), 32'(fidx + 1));
    check("mosi_frame", 32'(f_mosi[k][fidx]), 32'(f));
    check("mosi_bits", 32'(f_nb[k][fidx]), 32'd16);
    check("cs_low_len", 32'(f_low[k][fidx]), 32'(34 * dv(k)));
    wait_ready(k);
    check("rsp_pulses", 32'(pulses[k] - base), 32'd1);
  endtask

  initial begin
    logic [15:0] mwa, mwb;
    int fidx, base, t;
    rst_v = '1; cv = '0; crw = '0;
    caddr[0] = '0; caddr[1] = '0; cwd[0] = '0; cwd[1] = '0;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      check("reset_state",
            {busy_w[k], cs_w[k], sclk_w[k], mosi_w[k], ready_w[k], rv_w[k], rdata_w[k]},
            {18'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_v = '0;
    @(negedge clk);
    check("ready_after_reset", 32'(ready_w), 32'h3);

    // Directed write and read at CLK_DIV=2
    do_txn(0, 1'b0, 7'h15, 8'hA5, 16'h1234, 1'b0);
    do_txn(0, 1'b1, 7'h7F, 8'hC3, 16'h5A3C, 1'b0);

    // Back-to-back at CLK_DIV=1 with cmd_valid held
    mwa = 16'($urandom); mwb = 16'($urandom);
    miso_word[1] = mwa;
    @(negedge clk);
    wait_ready(1);
    fidx = f_n[1]; base = pulses[1];
    cv[1] = 1'b1; crw[1] = 1'b0; caddr[1] = 7'h2A; cwd[1] = 8'h5C;
    @(posedge clk);
    #1;
    crw[1] = 1'b1; caddr[1] = 7'h41; cwd[1] = 8'hFF;
    repeat (2) @(negedge clk);
    miso_word[1] = mwb;
    t = 0;
    while (!ready_w[1] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("b2b_ready", 32'(ready_w[1]), 32'd1);
    @(posedge clk);
    #1;
    cv[1] = 1'b0;
    t = 0;
    while (f_n[1] < fidx + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("b2b_frames", 32'(f_n[1]), 32'(fidx + 2));
    check("b2b_mosi_a", 32'(f_mosi[1][fidx]), 32'(exp_frame(1'b0, 7'h2A, 8'h5C)));
    check("b2b_mosi_b", 32'(f_mosi[1][fidx + 1]), 32'(exp_frame(1'b1, 7'h41, 8'hFF)));
    check("b2b_rd_a", 32'(f_rd[1][fidx]), 32'(mwa[7:0]));
    check("b2b_rd_b", 32'(f_rd[1][fidx + 1]), 32'(mwb[7:0]));
    check("b2b_low_b", 32'(f_low[1][fidx + 1]), 32'd34);
    check("b2b_high_gap", 32'(f_high[1][fidx + 1]), 32'd2);
    check("b2b_pulses", 32'(pulses[1] - base), 32'd2);

    // Reset during the 9th SCLK high phase at CLK_DIV=2
    miso_word[0] = 16'hFFFF;
    @(negedge clk);
    wait_ready(0);
    base = pulses[0];
    cv[0] = 1'b1; crw[0] = 1'b0; caddr[0] = 7'h33; cwd[0] = 8'h99;
    @(posedge clk);
    #1;
    cv[0] = 1'b0;
    t = 0;
    while (!(nb[0] == 9 && sclk_w[0]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_bit9", 32'(nb[0]), 32'd9);
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("abort_pins", {busy_w[0], cs_w[0], sclk_w[0], ready_w[0], rv_w[0]},
          {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_v[0] = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready_w[0]), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_no_rsp", 32'(pulses[0] - base), 32'd0);
    check("abort_bits", 32'(f_nb[0][f_n[0] - 1]), 32'd9);
    do_txn(0, 1'b0, 7'h0B, 8'h6E, 16'h00C7, 1'b0);

    // Command pulse and address toggle while busy
    do_txn(0, 1'b0, 7'h5A, 8'h3D, 16'h8E11, 1'b1);
    do_txn(1, 1'b1, 7'h26, 8'h77, 16'h71E4, 1'b1);

    // Randomized commands on both instances
    for (int i = 0; i < 8; i++)
      do_txn(i % 2, 1'($urandom), 7'($urandom), 8'($urandom), 16'($urandom), 1'b0);

    check("mosi_zero_after_16", 32'(tail_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dl_spi_master.md
DL_SPI_MASTER -- requirements
Module: dl_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 The module SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-003 clk  input  1  system controller clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_rw  input  1  1=read, 0=write.
REQ-008 cmd_addr  input  7  delay-line register address.
REQ-009 cmd_wdata  input  8  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse, transaction complete.
REQ-011 rsp_rdata  output  8  data captured from spi_miso; held until next rsp_valid.
REQ-012 busy  output  1  high from command accept until return to IDLE.
REQ-013 spi_cs_n  output  1  chip select, active-low.
REQ-014 spi_sclk  output  1  serial clock, SPI mode 0 (idle low).
REQ-015 spi_mosi  output  1  serial data to the delay-line SPI interface.
REQ-016 spi_miso  input  1  serial data from the delay-line SPI interface; already synchronous to clk.

Function
REQ-017 Frame SHALL be 16 bits, MSB first: {cmd_rw, cmd_addr[6:0], cmd_wdata[7:0]}; for reads, the low 8 MOSI bits SHALL be 0.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted in the cycle cmd_valid & cmd_ready, with all fields latched then.
REQ-019 States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE; no other transitions except reset.
REQ-020 IDLE: cs_n=1, sclk=0, mosi=0, busy=0. On accept: next cycle SETUP, cs_n=0, mosi=frame bit 15, busy=1.
REQ-021 SETUP SHALL last CLK_DIV cycles, with sclk=0.
REQ-022 SHIFT SHALL produce 16 SCLK periods; each is CLK_DIV cycles high, then CLK_DIV cycles low.
REQ-023 spi_miso SHALL be sampled in the cycle sclk goes 0->1; the last 8 samples form rsp_rdata, MSB first.
REQ-024 mosi SHALL advance to the next frame bit in the cycle sclk goes 1->0, for bits 14..0; after the 16th falling edge, mosi SHALL be 0.
REQ-025 HOLD SHALL last CLK_DIV cycles after the 16th low phase, with cs_n=0 and sclk=0.
REQ-026 At HOLD exit: cs_n=1 and rsp_valid=1 for exactly one cycle (reads and writes), and rsp_rdata updated in that same cycle.
REQ-027 GAP SHALL last CLK_DIV cycles with cs_n=1, then enter IDLE; cmd_ready SHALL rise on the IDLE entry cycle.
REQ-028 cs_n low time SHALL be exactly CLK_DIV*34 cycles per transaction.
REQ-029 The divider counter SHALL be 8 bits and the bit counter 5 bits; neither SHALL wrap mid-frame.
REQ-030 cmd_valid while busy SHALL be ignored; command inputs changing while busy SHALL NOT affect the frame in flight.
REQ-031 Back-to-back commands: cmd_valid held high SHALL be accepted on the IDLE entry cycle, with no extra idle cycle.

Reset
REQ-032 With rst=1 at a clk edge, the next state SHALL be: IDLE, cs_n=1, sclk=0, mosi=0, cmd_ready=0 while rst=1, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-033 Reset mid-transaction SHALL abort the frame immediately, with no rsp_valid pulse; cmd_ready SHALL rise in the first cycle after rst falls.

Verification
REQ-034 CLK_DIV=2, write addr 0x15 data 0xA5: MOSI bits sampled on SCLK rising edges = 0x15A5; cs_n low 68 cycles; rsp_valid pulses once.
REQ-035 CLK_DIV=2, read addr 0x7F, MISO model returns 0x3C in the data phase: MOSI = 0xFF00; rsp_rdata=0x3C at the rsp_valid pulse.
REQ-036 CLK_DIV=1, two commands with cmd_valid held high: two frames separated by exactly 1 cs_n-high cycle plus 1 IDLE cycle; both frames correct.
REQ-037 rst asserted during the 9th SCLK high phase: next cycle cs_n=1 and sclk=0; no rsp_valid; a following write transfers a correct frame.
REQ-038 cmd_valid pulsed while busy, and cmd_addr toggled mid-frame: the pulse is ignored, and the frame matches the fields latched at accept.
